// File: rtl/datapath_seq_pkg.sv
// -----------------------------------------------------------------------------
// datapath_seq_pkg
// Shared types and constants for the datapath program sequencer: opcode and
// FSM state enums, write-back source selects, the instruction field layout
// and the control bundle driven into the 16-register ALU datapath.
// -----------------------------------------------------------------------------
package datapath_seq_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned REG_AW  = 4;
    localparam int unsigned OP_W    = 3;
    localparam int unsigned SEL_W   = 4;
    localparam int unsigned IMM_W   = 8;

    // Instruction opcodes; any encoding not listed executes as a NOP
    typedef enum logic [3:0] {
        OPC_ADD  = 4'h0,
        OPC_SUB  = 4'h1,
        OPC_CMP  = 4'h2,
        OPC_AND  = 4'h3,
        OPC_MOV  = 4'h4,
        OPC_LDI  = 4'h8,
        OPC_IN   = 4'h9,
        OPC_JMP  = 4'hA,
        OPC_JZ   = 4'hB,
        OPC_HALT = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_DECODE = 2'd2,
        S_EXEC   = 2'd3
    } state_e;

    // Write-back source selects
    localparam logic [SEL_W-1:0] SEL_ALU = 4'd0;
    localparam logic [SEL_W-1:0] SEL_IMM = 4'd1;
    localparam logic [SEL_W-1:0] SEL_IN  = 4'd2;

    // Instruction word; imm8/jump target overlays the raa/rab fields
    typedef struct packed {
        logic [3:0]        opcode;
        logic [REG_AW-1:0] wa;
        logic [REG_AW-1:0] raa;
        logic [REG_AW-1:0] rab;
    } instr_t;

    // Datapath control bundle
    typedef struct packed {
        logic              wen;
        logic [REG_AW-1:0] wa;
        logic [REG_AW-1:0] raa;
        logic [REG_AW-1:0] rab;
        logic [OP_W-1:0]   op;
        logic [SEL_W-1:0]  sel;
        logic [IMM_W-1:0]  ctrl;
    } ctl_t;

    // Low byte of the instruction: immediate or jump target
    function automatic logic [IMM_W-1:0] instr_imm8(input instr_t ir);
        return {ir.raa, ir.rab};
    endfunction

endpackage

// File: rtl/datapath_decoder.sv
// -----------------------------------------------------------------------------
// datapath_decoder
// Combinational instruction decoder: maps an instruction word onto the
// datapath control bundle plus the sequencing flags used in EXEC.
// Ports:
//   i_instr     in  16      instruction word
//   o_ctl       out ctl_t   Wen/WA/RAA/RAB/Op/Sel/Ctrl for this instruction
//   o_jump      out 1       instruction is JMP or JZ
//   o_cond      out 1       jump is conditional on the stored zero flag
//   o_flag_upd  out 1       ALU op whose Flag result must be captured
//   o_halt      out 1       HALT
//   o_target    out ADDR_W  jump target
// -----------------------------------------------------------------------------
module datapath_decoder
    import datapath_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic [INSTR_W-1:0] i_instr,
    output ctl_t               o_ctl,
    output logic               o_jump,
    output logic               o_cond,
    output logic               o_flag_upd,
    output logic               o_halt,
    output logic [ADDR_W-1:0]  o_target
);

    instr_t w_ir;

    assign w_ir     = instr_t'(i_instr);
    assign o_target = ADDR_W'(instr_imm8(w_ir));

    // Opcode decode; unlisted opcodes leave everything inactive (NOP)
    always_comb begin
        o_ctl      = '0;
        o_jump     = 1'b0;
        o_cond     = 1'b0;
        o_flag_upd = 1'b0;
        o_halt     = 1'b0;
        case (w_ir.opcode)
            OPC_ADD, OPC_SUB, OPC_AND, OPC_MOV: begin
                o_ctl.wen  = 1'b1;
                o_ctl.wa   = w_ir.wa;
                o_ctl.raa  = w_ir.raa;
                o_ctl.rab  = w_ir.rab;
                o_ctl.op   = w_ir.opcode[OP_W-1:0];
                o_ctl.sel  = SEL_ALU;
                o_flag_upd = 1'b1;
            end
            OPC_CMP: begin
                // Compare runs the ALU for its flag only; no write-back
                o_ctl.raa  = w_ir.raa;
                o_ctl.rab  = w_ir.rab;
                o_ctl.op   = w_ir.opcode[OP_W-1:0];
                o_ctl.sel  = SEL_ALU;
                o_flag_upd = 1'b1;
            end
            OPC_LDI: begin
                o_ctl.wen  = 1'b1;
                o_ctl.wa   = w_ir.wa;
                o_ctl.sel  = SEL_IMM;
                o_ctl.ctrl = instr_imm8(w_ir);
            end
            OPC_IN: begin
                o_ctl.wen  = 1'b1;
                o_ctl.wa   = w_ir.wa;
                o_ctl.sel  = SEL_IN;
            end
            OPC_JMP: begin
                o_jump     = 1'b1;
            end
            OPC_JZ: begin
                o_jump     = 1'b1;
                o_cond     = 1'b1;
            end
            OPC_HALT: begin
                o_halt     = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/datapath_sequencer.sv
// -----------------------------------------------------------------------------
// datapath_sequencer
// Program sequencer for the 16-register ALU datapath. Fetches instructions
// from a synchronous ROM, decodes them and drives the datapath controls for
// one EXEC cycle per instruction (FETCH -> DECODE -> EXEC, 3 cycles each).
// Ports:
//   clk, rst          clock (rising edge), async active-high reset
//   start             begin execution at address 0 (honoured in IDLE only)
//   imem_addr/_data   ROM address out, ROM data in (one-cycle latency)
//   Wen/WA/RAA/RAB    register-file write enable and addresses
//   Op/Sel/Ctrl       ALU op, write-back source, immediate
//   Flag              datapath zero flag, sampled at the end of ALU EXECs
//   busy/done/error   run status; done/error pulse as IDLE is re-entered
// -----------------------------------------------------------------------------
module datapath_sequencer
    import datapath_seq_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned MAX_STEPS = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic [INSTR_W-1:0]  imem_data,
    output logic                Wen,
    output logic [REG_AW-1:0]   WA,
    output logic [REG_AW-1:0]   RAA,
    output logic [REG_AW-1:0]   RAB,
    output logic [OP_W-1:0]     Op,
    output logic [SEL_W-1:0]    Sel,
    output logic [IMM_W-1:0]    Ctrl,
    input  logic                Flag,
    output logic                busy,
    output logic                done,
    output logic                error
);

    localparam int unsigned STEP_W = $clog2(MAX_STEPS + 1);

    state_e               r_state;
    logic [INSTR_W-1:0]   r_ir;
    logic [ADDR_W-1:0]    r_pc;
    logic                 r_flag_q;
    logic [STEP_W-1:0]    r_steps;
    logic                 r_last;

    logic [INSTR_W-1:0]   w_instr;
    ctl_t                 w_ctl;
    logic                 w_jump;
    logic                 w_cond;
    logic                 w_flag_upd;
    logic                 w_halt;
    logic [ADDR_W-1:0]    w_target;
    logic                 w_last;
    logic                 w_taken;
    logic [ADDR_W-1:0]    w_next_pc;

    // Decode the ROM word directly in DECODE so the controls can be
    // registered into EXEC; in EXEC the latched IR drives sequencing.
    assign w_instr = (r_state == S_DECODE) ? imem_data : r_ir;

    datapath_decoder #(
        .ADDR_W     (ADDR_W)
    ) u_decoder (
        .i_instr    (w_instr),
        .o_ctl      (w_ctl),
        .o_jump     (w_jump),
        .o_cond     (w_cond),
        .o_flag_upd (w_flag_upd),
        .o_halt     (w_halt),
        .o_target   (w_target)
    );

    // The instruction about to enter EXEC is the last one allowed
    assign w_last    = (r_steps == STEP_W'(MAX_STEPS - 1));
    assign w_taken   = w_jump & (~w_cond | r_flag_q);
    assign w_next_pc = w_taken ? w_target : r_pc + ADDR_W'(1);

    // Sequencer FSM with registered datapath controls and status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ir      <= '0;
            r_pc      <= '0;
            r_flag_q  <= 1'b0;
            r_steps   <= '0;
            r_last    <= 1'b0;
            imem_addr <= '0;
            Wen       <= 1'b0;
            WA        <= '0;
            RAA       <= '0;
            RAB       <= '0;
            Op        <= '0;
            Sel       <= '0;
            Ctrl      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_FETCH;
                        r_pc      <= '0;
                        imem_addr <= '0;
                        r_flag_q  <= 1'b0;
                        r_steps   <= '0;
                        busy      <= 1'b1;
                    end
                end
                S_FETCH: begin
                    r_state <= S_DECODE;
                end
                S_DECODE: begin
                    r_ir    <= imem_data;
                    r_last  <= w_last;
                    // A step-limit abort suppresses this instruction's write
                    Wen     <= w_ctl.wen & ~w_last;
                    WA      <= w_ctl.wa;
                    RAA     <= w_ctl.raa;
                    RAB     <= w_ctl.rab;
                    Op      <= w_ctl.op;
                    Sel     <= w_ctl.sel;
                    Ctrl    <= w_ctl.ctrl;
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    Wen     <= 1'b0;
                    WA      <= '0;
                    RAA     <= '0;
                    RAB     <= '0;
                    Op      <= '0;
                    Sel     <= '0;
                    Ctrl    <= '0;
                    r_steps <= r_steps + STEP_W'(1);
                    if (w_flag_upd) begin
                        r_flag_q <= Flag;
                    end
                    if (r_last) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                        error   <= 1'b1;
                    end else if (w_halt) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        r_state   <= S_FETCH;
                        r_pc      <= w_next_pc;
                        imem_addr <= w_next_pc;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_datapath_sequencer.sv
// -----------------------------------------------------------------------------
// tb_datapath_sequencer
// Directed bench: small programs loaded into a behavioural synchronous ROM,
// per-cycle output trace captured at the falling edge and compared against
// hand-computed expectations. Cycle 1 is the first cycle after start is
// sampled (FETCH of address 0).
// -----------------------------------------------------------------------------
module tb_datapath_sequencer;

    localparam int unsigned ADDR_W    = 8;
    localparam int unsigned MAX_STEPS = 8;
    localparam int          NCYC      = 32;
    localparam int          NVEC      = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data;
    logic        Wen;
    logic [3:0]  WA, RAA, RAB;
    logic [2:0]  Op;
    logic [3:0]  Sel;
    logic [7:0]  Ctrl;
    logic        Flag;
    logic        busy, done, error;

    logic        flag_alu;
    logic        flag_cmp;
    logic [15:0] rom [256];

    int checks   = 0;
    int failures = 0;

    datapath_sequencer #(
        .ADDR_W    (ADDR_W),
        .MAX_STEPS (MAX_STEPS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .Wen       (Wen),
        .WA        (WA),
        .RAA       (RAA),
        .RAB       (RAB),
        .Op        (Op),
        .Sel       (Sel),
        .Ctrl      (Ctrl),
        .Flag      (Flag),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    // Synchronous ROM, one-cycle read latency
    always @(posedge clk) imem_data <= rom[imem_addr];

    // Zero flag stimulus: separate value for CMP so its capture is visible
    assign Flag = (Op == 3'b010) ? flag_cmp : flag_alu;

    typedef struct packed {
        logic       wen;
        logic [3:0] wa;
        logic [3:0] raa;
        logic [3:0] rab;
        logic [2:0] op;
        logic [3:0] sel;
        logic [7:0] ctrl;
        logic [7:0] addr;
        logic       busy;
        logic       done;
        logic       error;
    } obs_t;

    typedef struct {
        int   cyc;
        obs_t exp;
        bit   use_addr;
    } vec_t;

    obs_t tr [0:NCYC];
    vec_t tbl [NVEC];

    function automatic obs_t mk(input int wen, input int wa, input int raa, input int rab,
                                input int op, input int sel, input int ctrl, input int addr,
                                input int bsy, input int dn, input int er);
        obs_t o;
        o.wen   = 1'(wen);
        o.wa    = 4'(wa);
        o.raa   = 4'(raa);
        o.rab   = 4'(rab);
        o.op    = 3'(op);
        o.sel   = 4'(sel);
        o.ctrl  = 8'(ctrl);
        o.addr  = 8'(addr);
        o.busy  = 1'(bsy);
        o.done  = 1'(dn);
        o.error = 1'(er);
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.wen   = Wen;
        o.wa    = WA;
        o.raa   = RAA;
        o.rab   = RAB;
        o.op    = Op;
        o.sel   = Sel;
        o.ctrl  = Ctrl;
        o.addr  = imem_addr;
        o.busy  = busy;
        o.done  = done;
        o.error = error;
        return o;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Compare a full observation; imem_addr only where it is meaningful
    task automatic chk_obs(input string name, input obs_t act, input obs_t exp, input bit use_addr);
        obs_t a;
        a = act;
        if (!use_addr) a.addr = exp.addr;
        chk(name, 64'(a), 64'(exp));
    endtask

    // which: 0 = Wen, 1 = done, 2 = error
    function automatic int count_hi(input int which);
        int n = 0;
        for (int c = 1; c <= NCYC; c++) begin
            case (which)
                0:       n += int'(tr[c].wen);
                1:       n += int'(tr[c].done);
                default: n += int'(tr[c].error);
            endcase
        end
        return n;
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 16'h5000;  // NOP
    endtask

    // Pulse start, then capture NCYC cycles; extra[c] drives start in cycle c
    task automatic run(input logic [NCYC:0] extra);
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= NCYC; c++) begin
            @(posedge clk);
            #1 start = extra[c];
            @(negedge clk);
            tr[c] = sample();
        end
        start = 1'b0;
    endtask

    task automatic apply_table(input string tag);
        for (int i = 0; i < NVEC; i++) begin
            chk_obs($sformatf("%s_c%0d", tag, tbl[i].cyc), tr[tbl[i].cyc],
                    tbl[i].exp, tbl[i].use_addr);
        end
    endtask

    task automatic load_prog1();
        clear_rom();
        rom[0] = 16'h8105;  // LDI R1,0x05
        rom[1] = 16'h8205;  // LDI R2,0x05
        rom[2] = 16'h1312;  // SUB R3,R1,R2
        rom[3] = 16'hB006;  // JZ 0x06
        rom[4] = 16'h4410;  // MOV R4,R1
        rom[5] = 16'hF000;  // HALT
        rom[6] = 16'hF000;  // HALT
    endtask

    initial begin
        logic [NCYC:0] no_extra;
        logic [NCYC:0] busy_starts;
        obs_t          o;
        int            seen;

        no_extra    = '0;
        busy_starts = '0;
        busy_starts[2]  = 1'b1;
        busy_starts[5]  = 1'b1;
        busy_starts[10] = 1'b1;
        busy_starts[15] = 1'b1;

        // Expected trace of program 1 with the zero flag set (JZ taken)
        tbl[0] = '{1,  mk(0,0,0,0,0,0,0,    0,1,0,0), 1'b1};
        tbl[1] = '{3,  mk(1,1,0,0,0,1,8'h05,0,1,0,0), 1'b0};
        tbl[2] = '{4,  mk(0,0,0,0,0,0,0,    1,1,0,0), 1'b1};
        tbl[3] = '{6,  mk(1,2,0,0,0,1,8'h05,0,1,0,0), 1'b0};
        tbl[4] = '{9,  mk(1,3,1,2,1,0,0,    0,1,0,0), 1'b0};
        tbl[5] = '{12, mk(0,0,0,0,0,0,0,    0,1,0,0), 1'b0};
        tbl[6] = '{13, mk(0,0,0,0,0,0,0,    6,1,0,0), 1'b1};
        tbl[7] = '{15, mk(0,0,0,0,0,0,0,    0,1,0,0), 1'b0};
        tbl[8] = '{16, mk(0,0,0,0,0,0,0,    0,0,1,0), 1'b0};
        tbl[9] = '{17, mk(0,0,0,0,0,0,0,    0,0,0,0), 1'b0};

        rst      = 1'b1;
        start    = 1'b0;
        flag_alu = 1'b0;
        flag_cmp = 1'b0;
        clear_rom();

        // Reset state
        repeat (3) @(negedge clk);
        chk_obs("reset_held", sample(), mk(0,0,0,0,0,0,0,0,0,0,0), 1'b1);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk_obs("reset_idle", sample(), mk(0,0,0,0,0,0,0,0,0,0,0), 1'b1);

        // Program 1, Flag=1: JZ taken to 0x06
        load_prog1();
        flag_alu = 1'b1;
        run(no_extra);
        apply_table("p1");
        chk("p1_wen_count", 64'(count_hi(0)), 64'd3);
        chk("p1_done_count", 64'(count_hi(1)), 64'd1);

        // Program 1, Flag=0: JZ falls through to MOV at 0x04
        flag_alu = 1'b0;
        run(no_extra);
        chk_obs("p2_fetch4", tr[13], mk(0,0,0,0,0,0,0,4,1,0,0), 1'b1);
        chk_obs("p2_mov",    tr[15], mk(1,4,1,0,4,0,0,0,1,0,0), 1'b0);
        chk_obs("p2_fetch5", tr[16], mk(0,0,0,0,0,0,0,5,1,0,0), 1'b1);
        chk_obs("p2_done",   tr[19], mk(0,0,0,0,0,0,0,0,0,1,0), 1'b0);
        chk("p2_wen_count", 64'(count_hi(0)), 64'd4);

        // CMP captures its flag over the earlier MOV's: zero flag from CMP = 0
        clear_rom();
        rom[0] = 16'h4510;  // MOV R5,R1
        rom[1] = 16'h2012;  // CMP R1,R2
        rom[2] = 16'hB005;  // JZ 0x05
        rom[3] = 16'hF000;  // HALT
        rom[5] = 16'hF000;  // HALT
        flag_alu = 1'b1;
        flag_cmp = 1'b0;
        run(no_extra);
        chk_obs("p3b_mov",     tr[3],  mk(1,5,1,0,4,0,0,0,1,0,0), 1'b0);
        chk_obs("p3b_cmp",     tr[6],  mk(0,0,1,2,2,0,0,0,1,0,0), 1'b0);
        chk_obs("p3b_fetch3",  tr[10], mk(0,0,0,0,0,0,0,3,1,0,0), 1'b1);
        chk("p3b_done", 64'(tr[13].done), 64'd1);

        // Same program, CMP flag = 1: JZ taken
        flag_alu = 1'b0;
        flag_cmp = 1'b1;
        run(no_extra);
        chk_obs("p3a_fetch5", tr[10], mk(0,0,0,0,0,0,0,5,1,0,0), 1'b1);
        chk("p3a_wen_count", 64'(count_hi(0)), 64'd1);

        // Stored flag is 1 here; start must clear it so a leading JZ falls through
        clear_rom();
        rom[0] = 16'hB005;  // JZ 0x05
        rom[1] = 16'hF000;  // HALT
        rom[5] = 16'hF000;  // HALT
        run(no_extra);
        chk_obs("p4_fetch1", tr[4], mk(0,0,0,0,0,0,0,1,1,0,0), 1'b1);
        chk("p4_done", 64'(tr[7].done), 64'd1);

        // Runaway JMP loop: abort on the 8th EXEC (cycle 24), error in cycle 25
        clear_rom();
        rom[0] = 16'hA000;  // JMP 0x00
        run(no_extra);
        chk_obs("p5_fetch_loop", tr[22], mk(0,0,0,0,0,0,0,0,1,0,0), 1'b1);
        chk_obs("p5_exec8",      tr[24], mk(0,0,0,0,0,0,0,0,1,0,0), 1'b0);
        chk_obs("p5_error",      tr[25], mk(0,0,0,0,0,0,0,0,0,0,1), 1'b0);
        chk("p5_error_count", 64'(count_hi(2)), 64'd1);
        chk("p5_done_count",  64'(count_hi(1)), 64'd0);
        chk("p5_wen_count",   64'(count_hi(0)), 64'd0);

        // start pulses while busy are ignored: identical trace to program 1
        load_prog1();
        flag_alu = 1'b1;
        flag_cmp = 1'b0;
        run(busy_starts);
        apply_table("p6");
        chk("p6_wen_count", 64'(count_hi(0)), 64'd3);

        // Reset asserted during EXEC of ADD
        clear_rom();
        rom[0] = 16'h0123;  // ADD R1,R2,R3
        rom[1] = 16'hF000;  // HALT
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        chk_obs("rst_exec", sample(), mk(0,0,0,0,0,0,0,0,0,0,0), 1'b1);
        @(posedge clk);
        #2 rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            o = sample();
            if (o.wen || o.busy || o.done || o.error) seen++;
        end
        chk("rst_stays_idle", 64'(seen), 64'd0);

        // Recovers cleanly after the reset
        run(no_extra);
        chk_obs("p7_add",  tr[3], mk(1,1,2,3,0,0,0,0,1,0,0), 1'b0);
        chk_obs("p7_done", tr[7], mk(0,0,0,0,0,0,0,0,0,1,0), 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
